// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - state, ALU-op and condition-code definitions for mc_controller
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_LINK
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // nzcv = {N, Z, C, V}; the 1111 encoding falls through to false
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: return z;
            COND_NE: return !z;
            COND_CS: return c;
            COND_CC: return !c;
            COND_MI: return n;
            COND_PL: return !n;
            COND_VS: return v;
            COND_VC: return !v;
            COND_HI: return c && !z;
            COND_LS: return !c || z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return !z && (n == v);
            COND_LE: return z || (n != v);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Returns {legal, alu_op} for the data-processing cmd field
    function automatic logic [3:0] alu_decode(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return {1'b1, ALU_ADD};
            4'b0010: return {1'b1, ALU_SUB};
            4'b0000: return {1'b1, ALU_AND};
            4'b1100: return {1'b1, ALU_ORR};
            4'b0001: return {1'b1, ALU_EOR};
            default: return {1'b0, ALU_ADD};
        endcase
    endfunction

endpackage

// File: rtl/mc_cond_unit.sv
// rtl/mc_cond_unit.sv - NZCV flags register and condition evaluation
module mc_cond_unit
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       nz_we,
    input  logic       cv_we,
    output logic       cond_ex
);

    logic [3:0] flags_q, flags_d;

    always_comb begin
        flags_d = flags_q;
        if (nz_we) flags_d[3:2] = alu_flags[3:2];
        if (cv_we) flags_d[1:0] = alu_flags[1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) flags_q <= 4'b0000;
        else       flags_q <= flags_d;
    end

    assign cond_ex = cond_eval(cond, flags_q);

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle ARM-subset control FSM; BL/LINK support under MC_CONTROLLER_BL_EN
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            Op,
    input  logic [5:0]            Funct,
    input  logic [3:0]            Rd,
    input  logic [3:0]            Cond,
    input  logic [3:0]            ALUFlags,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  IRWrite,
    output logic                  MemW,
    output logic                  ByteMem,
    output logic                  RegW,
    output logic                  LinkW,
    output logic                  ALUSrcA,
    output logic                  IllegalOp,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ImmSrc,
    output logic [1:0]            RegSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl
);

    state_t     state_q, state_d;
    logic       cond_ex;
    logic       dp_legal;
    logic [2:0] dp_op;
    logic       is_exec;
    logic       nz_we, cv_we;

    logic       pc_write, adr_src, ir_write, mem_w, reg_w, link_w, alu_src_a, illegal;
    logic [1:0] result_src, alu_src_b, imm_src, reg_src;
    logic [2:0] alu_op;

    assign {dp_legal, dp_op} = alu_decode(Funct[4:1]);
    assign is_exec = (state_q == S_EXECR) || (state_q == S_EXECI);

    // Illegal DP ops and failed conditions leave the flags untouched
    assign nz_we = is_exec && dp_legal && cond_ex && Funct[0];
    assign cv_we = nz_we && ((dp_op == ALU_ADD) || (dp_op == ALU_SUB));

    mc_cond_unit u_cond (
        .clk       (clk),
        .reset     (reset),
        .cond      (Cond),
        .alu_flags (ALUFlags),
        .nz_we     (nz_we),
        .cv_we     (cv_we),
        .cond_ex   (cond_ex)
    );

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR, S_EXECI: state_d = dp_legal ? S_ALUWB : S_FETCH;
`ifdef MC_CONTROLLER_BL_EN
            S_BRANCH: state_d = (Funct[4] && cond_ex) ? S_LINK : S_FETCH;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        mem_w      = 1'b0;
        reg_w      = 1'b0;
        link_w     = 1'b0;
        alu_src_a  = 1'b0;
        illegal    = 1'b0;
        result_src = 2'b00;
        alu_src_b  = 2'b00;
        imm_src    = 2'b00;
        reg_src    = 2'b00;
        alu_op     = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                reg_src    = {Op == 2'b01, Op == 2'b10};
                imm_src    = Op;
                illegal    = (Op == 2'b11);
            end
            S_MEMADR: alu_src_b = 2'b01;
            S_MEMRD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = 2'b01;
                reg_w      = cond_ex;
            end
            S_MEMWR: begin
                adr_src = 1'b1;
                mem_w   = cond_ex;
            end
            S_EXECR, S_EXECI: begin
                alu_src_b = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                alu_op    = dp_op;
                illegal   = !dp_legal;
            end
            // A write to R15 redirects the PC instead of the register file
            S_ALUWB: begin
                reg_w    = cond_ex && (Rd != 4'hF);
                pc_write = cond_ex && (Rd == 4'hF);
            end
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = cond_ex;
            end
`ifdef MC_CONTROLLER_BL_EN
            S_LINK: begin
                result_src = 2'b10;
                reg_w      = cond_ex;
                link_w     = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign PCWrite    = pc_write  && !reset;
    assign IRWrite    = ir_write  && !reset;
    assign MemW       = mem_w     && !reset;
    assign RegW       = reg_w     && !reset;
    assign LinkW      = link_w    && !reset;
    assign IllegalOp  = illegal   && !reset;
    assign AdrSrc     = adr_src;
    assign ALUSrcA    = alu_src_a;
    assign ResultSrc  = result_src;
    assign ALUSrcB    = alu_src_b;
    assign ImmSrc     = imm_src;
    assign RegSrc     = reg_src;
    assign ALUControl = ALU_CTRL_W'(alu_op);
    assign ByteMem    = Funct[2] && ((state_q == S_MEMADR) || (state_q == S_MEMRD) ||
                                     (state_q == S_MEMWB)  || (state_q == S_MEMWR));

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench for mc_controller
module tb_mc_controller;

    localparam int F_FETCH = 0, F_DECODE = 1, F_MEMADR = 2, F_MEMRD = 3, F_MEMWB = 4, F_MEMWR = 5;
    localparam int F_EXECR = 6, F_EXECI = 7, F_ALUWB = 8, F_BRANCH = 9, F_LINK = 10;

    typedef struct {
        string      nm;
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] rd;
        logic [3:0] cond;
        logic [3:0] af;
    } instr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'b0;
    logic [3:0] Rd = 4'b0;
    logic [3:0] Cond = 4'b1110;
    logic [3:0] ALUFlags = 4'b0;
    logic       PCWrite, AdrSrc, IRWrite, MemW, ByteMem, RegW, LinkW, ALUSrcA, IllegalOp;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0] ALUControl;
    logic [19:0] obs;

    logic [19:0] sb[$];
    logic [3:0]  m_flags = 4'b0;
    int n_cmp = 0;
    int n_fail = 0;

    localparam logic [19:0] RST_VEC = {7'b0, 1'b1, 1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 3'b000};

    mc_controller #(.ALU_CTRL_W(3)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .MemW(MemW), .ByteMem(ByteMem), .RegW(RegW), .LinkW(LinkW), .ALUSrcA(ALUSrcA),
        .IllegalOp(IllegalOp), .ResultSrc(ResultSrc), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .ALUControl(ALUControl)
    );

    always #5 clk = ~clk;

    assign obs = {PCWrite, AdrSrc, IRWrite, MemW, ByteMem, RegW, LinkW, ALUSrcA, IllegalOp,
                  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl};

    function automatic instr_t mk(string nm, logic [1:0] op, logic [5:0] f, logic [3:0] rd,
                                  logic [3:0] cond, logic [3:0] af);
        instr_t i;
        i.nm = nm; i.op = op; i.f = f; i.rd = rd; i.cond = cond; i.af = af;
        return i;
    endfunction

    // ARM style: pairs of conditions share a base test, odd codes invert it
    function automatic logic m_cond(logic [3:0] c, logic [3:0] fl);
        logic n, z, cy, v, r;
        {n, z, cy, v} = fl;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy & ~z;
            3'd5: r = (n == v);
            3'd6: r = ~z & (n == v);
            default: r = 1'b1;
        endcase
        if (c == 4'b1110) return 1'b1;
        if (c == 4'b1111) return 1'b0;
        return c[0] ? ~r : r;
    endfunction

    function automatic int m_aluop(logic [3:0] cmd);
        if (cmd == 4'b0100) return 0;
        if (cmd == 4'b0010) return 1;
        if (cmd == 4'b0000) return 2;
        if (cmd == 4'b1100) return 3;
        if (cmd == 4'b0001) return 4;
        return -1;
    endfunction

    function automatic logic [19:0] exp_out(int st, logic [1:0] op, logic [5:0] f,
                                            logic [3:0] rd, logic ce);
        logic pcw, adr, irw, mw, bm, rw, lw, sa, il;
        logic [1:0] rs, sbx, is, rg;
        logic [2:0] alu;
        int a;
        {pcw, adr, irw, mw, bm, rw, lw, sa, il} = 9'b0;
        {rs, sbx, is, rg} = 8'b0;
        alu = 3'd0;
        a = m_aluop(f[4:1]);
        case (st)
            F_FETCH:  begin irw = 1; pcw = 1; sa = 1; sbx = 2'b10; rs = 2'b10; end
            F_DECODE: begin
                sa = 1; sbx = 2'b10; rs = 2'b10; is = op;
                rg[0] = (op == 2'b10); rg[1] = (op == 2'b01); il = (op == 2'b11);
            end
            F_MEMADR: begin sbx = 2'b01; bm = f[2]; end
            F_MEMRD:  begin adr = 1; bm = f[2]; end
            F_MEMWB:  begin rs = 2'b01; rw = ce; bm = f[2]; end
            F_MEMWR:  begin adr = 1; mw = ce; bm = f[2]; end
            F_EXECR, F_EXECI: begin
                sbx = (st == F_EXECI) ? 2'b01 : 2'b00;
                if (a < 0) il = 1; else alu = 3'(a);
            end
            F_ALUWB:  begin if (rd == 4'b1111) pcw = ce; else rw = ce; end
            F_BRANCH: begin sbx = 2'b01; rs = 2'b10; pcw = ce; end
            F_LINK:   begin rs = 2'b10; rw = 1; lw = 1; end
            default: ;
        endcase
        return {pcw, adr, irw, mw, bm, rw, lw, sa, il, rs, sbx, is, rg, alu};
    endfunction

    // Walks the instruction through the reference FSM, queueing one vector per cycle
    task automatic push_instr(input instr_t i, output int n);
        int st, nx, a;
        logic ce;
        st = F_FETCH;
        n = 0;
        while (1) begin
            ce = m_cond(i.cond, m_flags);
            sb.push_back(exp_out(st, i.op, i.f, i.rd, ce));
            n++;
            a = m_aluop(i.f[4:1]);
            nx = F_FETCH;
            case (st)
                F_FETCH:  nx = F_DECODE;
                F_DECODE: nx = (i.op == 2'b01) ? F_MEMADR : (i.op == 2'b10) ? F_BRANCH :
                               (i.op == 2'b11) ? F_FETCH : (i.f[5] ? F_EXECI : F_EXECR);
                F_MEMADR: nx = i.f[0] ? F_MEMRD : F_MEMWR;
                F_MEMRD:  nx = F_MEMWB;
                F_EXECR, F_EXECI: begin
                    nx = (a < 0) ? F_FETCH : F_ALUWB;
                    if (a >= 0 && ce && i.f[0]) begin
                        m_flags[3:2] = i.af[3:2];
                        if (a <= 1) m_flags[1:0] = i.af[1:0];
                    end
                end
`ifdef MC_CONTROLLER_BL_EN
                F_BRANCH: nx = (i.f[4] && ce) ? F_LINK : F_FETCH;
`endif
                default:  nx = F_FETCH;
            endcase
            st = nx;
            if (st == F_FETCH) break;
        end
    endtask

    task automatic apply(input instr_t i);
        Op = i.op; Funct = i.f; Rd = i.rd; Cond = i.cond; ALUFlags = i.af;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (obs !== RST_VEC) begin n_fail++; $display("FAIL reset_async got=%h exp=%h", obs, RST_VEC); end
        Op = 2'b11; Funct = 6'b011111;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (obs !== RST_VEC) begin n_fail++; $display("FAIL reset_held got=%h exp=%h", obs, RST_VEC); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_dp();
        instr_t t[6];
        int n;
        logic [19:0] e;
        t[0] = mk("ADD_R1_imm5", 2'b00, 6'b101000, 4'd1, 4'b1110, 4'b0000);
        t[1] = mk("SUB_reg",     2'b00, 6'b000100, 4'd3, 4'b1110, 4'b0000);
        t[2] = mk("AND_imm",     2'b00, 6'b100000, 4'd4, 4'b1110, 4'b0000);
        t[3] = mk("ORR_reg",     2'b00, 6'b011000, 4'd5, 4'b1110, 4'b0000);
        t[4] = mk("EOR_imm",     2'b00, 6'b100010, 4'd6, 4'b1110, 4'b0000);
        t[5] = mk("ADD_to_PC",   2'b00, 6'b001000, 4'hF, 4'b1110, 4'b0000);
        foreach (t[k]) begin
            push_instr(t[k], n);
            apply(t[k]);
            for (int c = 0; c < n; c++) begin
                if (c > 0) @(negedge clk);
                #1;
                e = sb.pop_front();
                n_cmp++;
                if (obs !== e) begin n_fail++; $display("FAIL dp_%s cyc%0d got=%h exp=%h", t[k].nm, c, obs, e); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mem();
        instr_t t[4];
        int n;
        logic [19:0] e;
        t[0] = mk("LDRB", 2'b01, 6'b011101, 4'd2, 4'b1110, 4'b0000);
        t[1] = mk("LDR",  2'b01, 6'b011001, 4'd2, 4'b1110, 4'b0000);
        t[2] = mk("STR",  2'b01, 6'b011000, 4'd2, 4'b1110, 4'b0000);
        t[3] = mk("STRB", 2'b01, 6'b011100, 4'd2, 4'b1110, 4'b0000);
        foreach (t[k]) begin
            push_instr(t[k], n);
            apply(t[k]);
            for (int c = 0; c < n; c++) begin
                if (c > 0) @(negedge clk);
                #1;
                e = sb.pop_front();
                n_cmp++;
                if (obs !== e) begin n_fail++; $display("FAIL mem_%s cyc%0d got=%h exp=%h", t[k].nm, c, obs, e); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        instr_t t[8];
        int n;
        logic [19:0] e;
        t[0] = mk("SUBS_Z",   2'b00, 6'b000101, 4'd0, 4'b1110, 4'b0100);
        t[1] = mk("BEQ",      2'b10, 6'b100000, 4'd0, 4'b0000, 4'b0000);
        t[2] = mk("BNE",      2'b10, 6'b100000, 4'd0, 4'b0001, 4'b0000);
        t[3] = mk("ADDNE",    2'b00, 6'b101000, 4'd1, 4'b0001, 4'b0000);
        t[4] = mk("ADDS_NV",  2'b00, 6'b001001, 4'd1, 4'b1110, 4'b1001);
        t[5] = mk("BGE",      2'b10, 6'b100000, 4'd0, 4'b1010, 4'b0000);
        t[6] = mk("BLT",      2'b10, 6'b100000, 4'd0, 4'b1011, 4'b0000);
        t[7] = mk("B_never",  2'b10, 6'b100000, 4'd0, 4'b1111, 4'b0000);
        foreach (t[k]) begin
            push_instr(t[k], n);
            apply(t[k]);
            for (int c = 0; c < n; c++) begin
                if (c > 0) @(negedge clk);
                #1;
                e = sb.pop_front();
                n_cmp++;
                if (obs !== e) begin n_fail++; $display("FAIL br_%s cyc%0d got=%h exp=%h", t[k].nm, c, obs, e); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        instr_t t[3];
        int n;
        logic [19:0] e;
        t[0] = mk("Op11",     2'b11, 6'b000000, 4'd1, 4'b1110, 4'b0000);
        t[1] = mk("DP_cmd15", 2'b00, 6'b011111, 4'd1, 4'b1110, 4'b0100);
        t[2] = mk("BEQ_post", 2'b10, 6'b100000, 4'd0, 4'b0000, 4'b0000);
        foreach (t[k]) begin
            push_instr(t[k], n);
            apply(t[k]);
            for (int c = 0; c < n; c++) begin
                if (c > 0) @(negedge clk);
                #1;
                e = sb.pop_front();
                n_cmp++;
                if (obs !== e) begin n_fail++; $display("FAIL ill_%s cyc%0d got=%h exp=%h", t[k].nm, c, obs, e); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bl();
        instr_t t[2];
        int n;
        logic [19:0] e;
        t[0] = mk("BL",    2'b10, 6'b010000, 4'd0, 4'b1110, 4'b0000);
        t[1] = mk("ADD_after", 2'b00, 6'b101000, 4'd1, 4'b1110, 4'b0000);
        foreach (t[k]) begin
            push_instr(t[k], n);
            apply(t[k]);
            for (int c = 0; c < n; c++) begin
                if (c > 0) @(negedge clk);
                #1;
                e = sb.pop_front();
                n_cmp++;
                if (obs !== e) begin n_fail++; $display("FAIL bl_%s cyc%0d got=%h exp=%h", t[k].nm, c, obs, e); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        instr_t t[3];
        int n;
        logic [19:0] e;
        t[0] = mk("SUBS_Z", 2'b00, 6'b000101, 4'd0, 4'b1110, 4'b0100);
        t[1] = mk("LDR",    2'b01, 6'b011001, 4'd2, 4'b1110, 4'b0000);
        t[2] = mk("BEQ",    2'b10, 6'b100000, 4'd0, 4'b0000, 4'b0000);
        foreach (t[k]) begin
            push_instr(t[k], n);
            apply(t[k]);
            for (int c = 0; c < n; c++) begin
                if (c > 0) @(negedge clk);
                #1;
                e = sb.pop_front();
                n_cmp++;
                if (obs !== e) begin n_fail++; $display("FAIL rmid_%s cyc%0d got=%h exp=%h", t[k].nm, c, obs, e); end
                if (k == 1 && c == 3) break;
            end
            if (k == 1) begin
                reset = 1'b1;
                #1;
                n_cmp++;
                if (obs !== RST_VEC) begin n_fail++; $display("FAIL rmid_async got=%h exp=%h", obs, RST_VEC); end
                sb.delete();
                m_flags = 4'b0000;
                repeat (2) @(negedge clk);
                reset = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_dp();
        test_mem();
        test_branch();
        test_illegal();
        test_bl();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
